// File: rtl/vx_tensor_mac_array_if.sv
// Operand/result bus of the tensor MAC tile engine.
// The dispatcher drives the master side. The engine sits on the slave side.
interface vx_tensor_mac_array_if #(
  parameter int M    = 2,
  parameter int N    = 4,
  parameter int K    = 2,
  parameter int WIDW = 4
);
  logic                valid_in;
  logic                ready_in;
  logic                acc_in;
  logic [M*K*32-1:0]   a_tile;
  logic [K*N*32-1:0]   b_tile;
  logic [M*N*32-1:0]   c_tile;
  logic [WIDW-1:0]     wid_in;
  logic                valid_out;
  logic                ready_out;
  logic [M*N*32-1:0]   d_tile;
  logic [WIDW-1:0]     wid_out;

  modport master (
    output valid_in, acc_in, a_tile, b_tile, c_tile, wid_in, ready_out,
    input  ready_in, valid_out, d_tile, wid_out
  );

  modport slave (
    input  valid_in, acc_in, a_tile, b_tile, c_tile, wid_in, ready_out,
    output ready_in, valid_out, d_tile, wid_out
  );
endinterface

// File: rtl/vx_tensor_mac_array.sv
// Tensor tile engine computing D = A*B + C with NUM_DP dot-product lanes over S substeps.
// Operands are buffered in a FIFO. An accumulate mode chains the previously delivered D in as C.
module vx_tensor_mac_array #(
  parameter int M         = 2,
  parameter int N         = 4,
  parameter int K         = 2,
  parameter int NUM_DP    = 4,
  parameter int LATENCY   = 3,
  parameter int BUF_DEPTH = 4,
  parameter int WIDW      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_tensor_mac_array_if.slave   io
);
  localparam int S  = (M * N) / NUM_DP;
  localparam int SW = (S > 1) ? $clog2(S) : 1;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int AW = M * K * 32;
  localparam int BW = K * N * 32;
  localparam int DW = M * N * 32;

  if (((M * N) % NUM_DP) != 0 || LATENCY < 1 || BUF_DEPTH < 2) begin : g_bad_params
    $error("vx_tensor_mac_array: illegal NUM_DP/LATENCY/BUF_DEPTH");
  end

  logic [AW-1:0]        fa_q [BUF_DEPTH];
  logic [AW-1:0]        fa_d [BUF_DEPTH];
  logic [BW-1:0]        fb_q [BUF_DEPTH];
  logic [BW-1:0]        fb_d [BUF_DEPTH];
  logic [DW-1:0]        fc_q [BUF_DEPTH];
  logic [DW-1:0]        fc_d [BUF_DEPTH];
  logic [WIDW-1:0]      fwid_q [BUF_DEPTH];
  logic [WIDW-1:0]      fwid_d [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] facc_q, facc_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        sub_q, sub_d;

  logic [LATENCY-1:0]   sv_q, sv_d;
  logic [31:0]          sres_q [LATENCY][NUM_DP];
  logic [31:0]          sres_d [LATENCY][NUM_DP];
  logic [SW-1:0]        ssub_q [LATENCY];
  logic [SW-1:0]        ssub_d [LATENCY];
  logic [WIDW-1:0]      swid_q [LATENCY];
  logic [WIDW-1:0]      swid_d [LATENCY];

  logic                 asm_busy_q, asm_busy_d;
  logic                 vout_q, vout_d;
  logic [DW-1:0]        d_q, d_d;
  logic [DW-1:0]        acc_q, acc_d;
  logic [WIDW-1:0]      wid_q, wid_d;

  logic [31:0]          lane_res [NUM_DP];
  logic                 full, empty, push, pe, in_flight, acc_block, issue, pop;

  assign io.ready_in  = reset && !full;
  assign io.valid_out = vout_q;
  assign io.d_tile    = d_q;
  assign io.wid_out   = wid_q;

  always_comb begin
    full      = (cnt_q == CW'(BUF_DEPTH));
    empty     = (cnt_q == '0);
    push      = io.valid_in && io.ready_in;
    pe        = !(vout_q && !io.ready_out);
    // An accumulating tile must see the accumulator after every older tile has left.
    in_flight = (|sv_q) || asm_busy_q || vout_q;
    acc_block = facc_q[rd_ptr_q] && (sub_q == '0) && in_flight;
    issue     = pe && !empty && !acc_block;
    pop       = issue && (sub_q == SW'(S - 1));
  end

  always_comb begin
    lane_res = '{default: '0};
    for (int unsigned i = 0; i < NUM_DP; i++) begin : g_lane
      automatic int unsigned j   = 32'(sub_q) * NUM_DP + i;
      automatic int unsigned row = j / N;
      automatic int unsigned col = j % N;
      automatic logic [31:0] sum = facc_q[rd_ptr_q] ? acc_q[j*32 +: 32]
                                                    : fc_q[rd_ptr_q][j*32 +: 32];
      for (int unsigned k = 0; k < K; k++)
        sum = sum + fa_q[rd_ptr_q][(row*K + k)*32 +: 32] * fb_q[rd_ptr_q][(k*N + col)*32 +: 32];
      lane_res[i] = sum;
    end
  end

  always_comb begin
    fa_d       = fa_q;
    fb_d       = fb_q;
    fc_d       = fc_q;
    fwid_d     = fwid_q;
    facc_d     = facc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sub_d      = sub_q;
    sv_d       = sv_q;
    sres_d     = sres_q;
    ssub_d     = ssub_q;
    swid_d     = swid_q;
    asm_busy_d = asm_busy_q;
    vout_d     = vout_q;
    d_d        = d_q;
    wid_d      = wid_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);

    if (push) begin
      fa_d[wr_ptr_q]   = io.a_tile;
      fb_d[wr_ptr_q]   = io.b_tile;
      fc_d[wr_ptr_q]   = io.c_tile;
      fwid_d[wr_ptr_q] = io.wid_in;
      facc_d[wr_ptr_q] = io.acc_in;
      wr_ptr_d = (wr_ptr_q == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop)
      rd_ptr_d = (rd_ptr_q == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    if (issue)
      sub_d = pop ? '0 : sub_q + 1'b1;
    if (vout_q && io.ready_out)
      acc_d = d_q;

    if (pe) begin
      sv_d[0]   = issue;
      sres_d[0] = lane_res;
      ssub_d[0] = sub_q;
      swid_d[0] = fwid_q[rd_ptr_q];
      for (int unsigned l = 1; l < LATENCY; l++) begin
        sv_d[l]   = sv_q[l-1];
        sres_d[l] = sres_q[l-1];
        ssub_d[l] = ssub_q[l-1];
        swid_d[l] = swid_q[l-1];
      end
      vout_d = 1'b0;
      if (sv_q[LATENCY-1]) begin
        for (int unsigned i = 0; i < NUM_DP; i++)
          d_d[(32'(ssub_q[LATENCY-1]) * NUM_DP + i)*32 +: 32] = sres_q[LATENCY-1][i];
        if (ssub_q[LATENCY-1] == SW'(S - 1)) begin
          vout_d     = 1'b1;
          wid_d      = swid_q[LATENCY-1];
          asm_busy_d = 1'b0;
        end else begin
          asm_busy_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      sub_q      <= '0;
      sv_q       <= '0;
      asm_busy_q <= 1'b0;
      vout_q     <= 1'b0;
      d_q        <= '0;
      wid_q      <= '0;
      acc_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      sub_q      <= sub_d;
      sv_q       <= sv_d;
      asm_busy_q <= asm_busy_d;
      vout_q     <= vout_d;
      d_q        <= d_d;
      wid_q      <= wid_d;
      acc_q      <= acc_d;
    end
    fa_q   <= fa_d;
    fb_q   <= fb_d;
    fc_q   <= fc_d;
    fwid_q <= fwid_d;
    facc_q <= facc_d;
    sres_q <= sres_d;
    ssub_q <= ssub_d;
    swid_q <= swid_d;
  end
endmodule
